mux_scan_reg: RTL and testbench
===============================

Name: mux_scan_reg

Overview:
- Parametrised, registered N:1 data multiplexer; the clocked successor of the team's combinational 2:1 select mux.
- Two modes:
  - manual: the channel is latched from a select bus.
  - scan: the channel auto-advances round-robin after a programmable dwell time.
- Sits between the input channel bank and downstream display/test logic.
- Reports the active channel and a wrap pulse for frame sync.

Parameters:
- W, 8: data width per channel.
- SEL_W, 2: select width; channel count N = 2**SEL_W.
- DWELL, 4: cycles each channel is held in scan mode; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  N*W  channel k occupies bits [k*W+W-1 : k*W].
- sel  input  SEL_W  requested channel.
- sel_load  input  1  latch sel into the active channel this cycle.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  global enable.
- out  output  W  registered selected data.
- out_valid  output  1  out holds a freshly sampled value this cycle.
- cur_sel  output  SEL_W  channel currently driving out.
- wrap  output  1  one-cycle pulse when scan advances from N-1 to 0.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high, sampled on the rising edge of clk.
  - rst overrides every other input, including mid-scan.
- Reset values:
  - out=0, out_valid=0, cur_sel=0, wrap=0.
  - Dwell counter=0; state=IDLE.
- States: IDLE, MANUAL, SCAN.
  - IDLE -> MANUAL or SCAN on the first cycle with en=1, chosen by mode.
  - MANUAL <-> SCAN whenever en=1 and mode changes.
  - There is no return to IDLE except via rst.
- next_sel priority, highest first:
  - (1) sel_load=1 -> sel.
  - (2) state SCAN and dwell counter = DWELL-1 -> (cur_sel+1) mod N.
  - (3) otherwise cur_sel.
- Datapath, latency 1:
  - On an edge with en=1: cur_sel <= next_sel; out <= in_bus slice[next_sel]; out_valid <= 1.
  - out and cur_sel are therefore always consistent.
  - In steady state, out tracks input changes on the held channel with 1-cycle latency.
- en=0:
  - out, cur_sel, dwell counter and state all hold.
  - out_valid <= 0; wrap <= 0.
- Dwell counter:
  - Active only in SCAN.
  - Increments each enabled cycle and returns to 0 on advance.
  - Also cleared on sel_load, on MANUAL->SCAN entry and on IDLE->SCAN entry.
  - DWELL=1 advances every enabled cycle.
- wrap:
  - Asserted for exactly the cycle in which cur_sel becomes 0 via an auto-advance from N-1.
  - Never asserted by sel_load, even if sel=0.
- Mode change SCAN->MANUAL: cur_sel holds its current value until the next sel_load.
- Mode change MANUAL->SCAN: scanning starts from the current cur_sel, with the full DWELL.
- sel_load in SCAN: jumps to sel and restarts the dwell phase; it wins over a coincident auto-advance.
- sel_load is ignored when en=0.

Optional Feature:
- MUX_SCAN_DEBUG_EN defined:
  - Adds output port dbg [7:0], registered and reset to 0.
  - dbg = {state[1:0], dwell_cnt[3:0], mode, en}, sampled every cycle regardless of en.
  - State encoding: IDLE=0, MANUAL=1, SCAN=2.
- MUX_SCAN_DEBUG_EN undefined: no dbg port and no debug register; all other behaviour is identical.

Test Plan:
Common setup: W=8, SEL_W=2, DWELL=4, in_bus channels = 0x11, 0x22, 0x33, 0x44.
1. rst=1 for 2 cycles, then en=0 -> out=0x00, out_valid=0, cur_sel=0, wrap=0; rst asserted mid-scan also returns to these values on the next edge.
2. Manual, en=1, sel=2, sel_load=1 for 1 cycle -> next edge cur_sel=2, out=0x33, out_valid=1; changing channel 2 to 0x5A shows out=0x5A one cycle later.
3. Scan from cur_sel=0 -> out steps 0x11, 0x22, 0x33, 0x44, 0x11 with 4 cycles each; wrap=1 only in the first cycle of the returning 0x11.
4. Scan, 2 cycles into channel 1, sel=3 with sel_load=1 -> out=0x44, then holds 4 full cycles; then wraps to 0x11 with wrap=1.
5. Scan with en dropped for 3 cycles mid-dwell -> out holds, out_valid=0; after re-enable the remaining dwell completes, with no extra or lost cycles.
6. Scan at channel 3 with dwell=DWELL-1 switched to mode=0 -> cur_sel stays 3, no advance, wrap=0.

Source files
------------

// File: rtl/mux_scan_reg.sv
// Registered N:1 channel multiplexer with manual select and round-robin scan.
// Define MUX_SCAN_DEBUG_EN to add the registered dbg status port.
module mux_scan_reg #(
  parameter int W     = 8,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(2**SEL_W)*W-1:0]    in_bus,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       sel_load,
  input  logic                       mode,
  input  logic                       en,
  output logic [W-1:0]               out,
  output logic                       out_valid,
  output logic [SEL_W-1:0]           cur_sel,
  output logic                       wrap
`ifdef MUX_SCAN_DEBUG_EN
  ,
  output logic [7:0]                 dbg
`endif
);

  localparam int N = 2**SEL_W;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       dwell_cnt, dwell_nx;
  logic [SEL_W-1:0] next_sel;
  logic             advance;

  // Next-state, select and dwell decode; only committed on enabled edges.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = mode ? SCAN : MANUAL;
    // A coincident mode change to manual or a sel_load both suppress the advance.
    advance  = (state == SCAN) && mode && (dwell_cnt == DWELL_LAST) && !sel_load;

    next_sel = cur_sel;
    if (sel_load)
      next_sel = sel;
    else if (advance)
      next_sel = cur_sel + SEL_W'(1);

    dwell_nx = dwell_cnt;
    if (sel_load || advance || (state_nx == SCAN && state != SCAN))
      dwell_nx = '0;
    else if (state == SCAN && state_nx == SCAN)
      dwell_nx = dwell_cnt + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      cur_sel   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (en) begin
      state     <= state_nx;
      dwell_cnt <= dwell_nx;
      cur_sel   <= next_sel;
      out       <= in_bus[int'(next_sel)*W +: W];
      out_valid <= 1'b1;
      wrap      <= advance && (cur_sel == LAST_CH);
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end
  end

`ifdef MUX_SCAN_DEBUG_EN
  // Status snapshot taken every cycle, independent of en.
  always_ff @(posedge clk) begin
    if (rst)
      dbg <= '0;
    else
      dbg <= {state, dwell_cnt[3:0], mode, en};
  end
`endif

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed, table-driven bench for mux_scan_reg (W=8, SEL_W=2, DWELL=4).
module tb_mux_scan_reg;

  localparam logic [31:0] D   = 32'h4433_2211;
  localparam logic [31:0] D5A = 32'h445A_2211;

  logic        clk = 1'b0;
  logic        rst, en, mode, sel_load;
  logic [1:0]  sel;
  logic [31:0] in_bus;
  logic [7:0]  out;
  logic        out_valid, wrap;
  logic [1:0]  cur_sel;
`ifdef MUX_SCAN_DEBUG_EN
  logic [7:0]  dbg;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mux_scan_reg #(.W(8), .SEL_W(2), .DWELL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .sel       (sel),
    .sel_load  (sel_load),
    .mode      (mode),
    .en        (en),
    .out       (out),
    .out_valid (out_valid),
    .cur_sel   (cur_sel),
    .wrap      (wrap)
`ifdef MUX_SCAN_DEBUG_EN
    ,
    .dbg       (dbg)
`endif
  );

  typedef struct {
    logic        rst, en, mode, sl;
    logic [1:0]  sel;
    logic [31:0] bus;
    logic [7:0]  e_out;
    logic        e_valid;
    logic [1:0]  e_cur;
    logic        e_wrap;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic e, logic m, logic sl, logic [1:0] s,
                              logic [31:0] b, logic [7:0] eo, logic ev,
                              logic [1:0] ec, logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sl = sl; v.sel = s; v.bus = b;
    v.e_out = eo; v.e_valid = ev; v.e_cur = ec; v.e_wrap = ew;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(logic r, logic e, logic m, logic sl, logic [1:0] s, logic [31:0] b);
    @(negedge clk);
    rst = r; en = e; mode = m; sel_load = sl; sel = s; in_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string tag, logic [7:0] eo, logic ev, logic [1:0] ec, logic ew);
    check({tag, ".out"},       32'(out),       32'(eo));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".cur_sel"},   32'(cur_sel),   32'(ec));
    check({tag, ".wrap"},      32'(wrap),      32'(ew));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_load = 1'b0; sel = '0; in_bus = D;

    //            rst en md sl sel bus   out    v  cur w
    // reset, held for two cycles; rst wins over en
    tv.push_back(mk(1, 0, 0, 0, 0, D,   8'h00, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 0, 0, D,   8'h00, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, D,   8'h00, 0, 0, 0));
    // manual load of channel 2, then track a data change on it
    tv.push_back(mk(0, 1, 0, 1, 2, D,   8'h33, 1, 2, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, D5A, 8'h5A, 1, 2, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, D,   8'h33, 1, 2, 0));
    // manual load of channel 0 never pulses wrap
    tv.push_back(mk(0, 1, 0, 1, 0, D,   8'h11, 1, 0, 0));
    // scan from channel 0, four cycles per channel, wrap on return to 0
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        tv.push_back(mk(0, 1, 1, 0, 0, D, 8'h11 * 8'(c + 1), 1, 2'(c), 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h11, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h11, 1, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h11, 1, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h11, 1, 0, 0));
    // two cycles into channel 1, then sel_load channel 3 restarts the dwell
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h22, 1, 1, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h22, 1, 1, 0));
    tv.push_back(mk(0, 1, 1, 1, 3, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h11, 1, 0, 1));
    // park on channel 3 at the last dwell cycle, then drop to manual
    tv.push_back(mk(0, 1, 1, 1, 3, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, D,   8'h44, 1, 3, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, D,   8'h44, 1, 3, 0));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].en, tv[i].mode, tv[i].sl, tv[i].sel, tv[i].bus);
      expect_out($sformatf("vec%0d", i), tv[i].e_out, tv[i].e_valid, tv[i].e_cur, tv[i].e_wrap);
    end

    // Enable gap mid-dwell: MANUAL->SCAN on channel 3, one more cycle, then
    // three disabled cycles (one with an ignored sel_load), then two more.
    step(0, 1, 1, 0, 0, D);  expect_out("gap.entry", 8'h44, 1, 3, 0);
    step(0, 1, 1, 0, 0, D);  expect_out("gap.c1",    8'h44, 1, 3, 0);
    step(0, 0, 1, 0, 0, D);  expect_out("gap.off0",  8'h44, 0, 3, 0);
    step(0, 0, 1, 1, 1, D);  expect_out("gap.off1",  8'h44, 0, 3, 0);
    step(0, 0, 1, 0, 0, D);  expect_out("gap.off2",  8'h44, 0, 3, 0);
    step(0, 1, 1, 0, 0, D);  expect_out("gap.c2",    8'h44, 1, 3, 0);
    step(0, 1, 1, 0, 0, D);  expect_out("gap.c3",    8'h44, 1, 3, 0);
    step(0, 1, 1, 0, 0, D);  expect_out("gap.adv",   8'h11, 1, 0, 1);

    // Reset mid-scan, then IDLE->SCAN entry gets the full dwell.
    step(0, 1, 1, 0, 0, D);  expect_out("rs.pre",    8'h11, 1, 0, 0);
    step(1, 1, 1, 0, 0, D);  expect_out("rs.rst",    8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 0, D);  expect_out("rs.idle",   8'h00, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 0, 0, D);
      expect_out($sformatf("rs.dw%0d", k), 8'h11, 1, 0, 0);
    end
    step(0, 1, 1, 0, 0, D);  expect_out("rs.adv",    8'h22, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
